ram256_requester: RTL and testbench

RAM256_REQUESTER -- requirements
Module: ram256_requester

---
 rtl/ram256_requester.sv | 96 +++++++++
 tb/tb_ram256_requester.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ram256_requester.sv
// ram256_requester: 64-bit core request port onto a 256-bit line RAM, with an optional
// single-line write-through read buffer.
module ram256_requester #(
  parameter int LINE_BUF = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [63:0]  req_addr,
  input  logic         req_wen,
  input  logic [63:0]  req_wdata,
  input  logic [7:0]   req_wmask,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [63:0]  resp_rdata,
  input  logic         buf_flush,
  output logic         ram_en,
  output logic [63:0]  ram_addr,
  output logic [255:0] ram_wdata,
  output logic [31:0]  ram_wmask,
  output logic         ram_wen,
  input  logic [255:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, nxt;
  logic [63:0] a_q, wdata_q, rdata_q;
  logic [7:0] wmask_q;
  logic wen_q;
  logic [255:0] buf_data, merged;
  logic [58:0] buf_tag;
  logic buf_valid;
  logic accept, hit, tag_match;
  logic [1:0] slot;
  logic [31:0] line_mask;
  assign slot = a_q[4:3];
  assign req_ready = state == IDLE;
  assign accept = req_valid && req_ready;
  assign hit = (LINE_BUF != 0) && buf_valid && !req_wen && buf_tag == req_addr[63:5];
  assign tag_match = buf_valid && buf_tag == a_q[63:5];
  assign line_mask = {24'b0, wmask_q} << {slot, 3'b000};
  assign ram_en = state == ACCESS;
  assign ram_wen = ram_en && wen_q;
  assign ram_wmask = ram_wen ? line_mask : '0;
  assign ram_addr = {5'b0, a_q[63:5]};
  assign ram_wdata = {4{wdata_q}};
  assign resp_valid = state == RESP;
  assign resp_rdata = rdata_q;
  always_comb begin
    nxt = state == IDLE   ? (accept ? (hit ? RESP : ACCESS) : IDLE) :
          state == ACCESS ? RESP :
          state == RESP   ? (resp_ready ? IDLE : RESP) : IDLE;
  end
  // write-through merge: only the enabled bytes of the written word replace buffered bytes
  always_comb begin
    merged = buf_data;
    for (int i = 0; i < 32; i++)
      if (line_mask[i]) merged[8*i +: 8] = ram_wdata[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      wen_q <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      buf_data <= '0;
      buf_tag <= '0;
      buf_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= req_addr;
        wen_q <= req_wen;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
        if (hit) rdata_q <= buf_data[{req_addr[4:3], 6'b0} +: 64];
      end
      if (ram_en) begin
        rdata_q <= wen_q ? '0 : ram_rdata[{slot, 6'b0} +: 64];
        if (!wen_q && LINE_BUF != 0) begin
          buf_data <= ram_rdata;
          buf_tag <= a_q[63:5];
          buf_valid <= 1'b1;
        end else if (wen_q && tag_match) begin
          buf_data <= merged;
        end
      end
      // flush overrides a same-cycle fill or merge by dropping the valid bit
      if (buf_flush) buf_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ram256_requester.sv
// tb_ram256_requester: directed vector table plus stall, flush-during-fill and reset-during-access sequences.
module tb_ram256_requester;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_wen = 0, resp_ready = 0, buf_flush = 0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [7:0] req_wmask = '0;
  logic req_ready, resp_valid, ram_en, ram_wen;
  logic [63:0] resp_rdata, ram_addr;
  logic [255:0] ram_wdata, ram_rdata;
  logic [31:0] ram_wmask;
  logic [255:0] mem [0:511];
  int en_cnt = 0;
  logic [63:0] last_addr = '0;
  logic [31:0] last_mask = '0;
  int vecs = 0, miss = 0;

  ram256_requester #(.LINE_BUF(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .buf_flush(buf_flush), .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask), .ram_wen(ram_wen), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  assign ram_rdata = mem[ram_addr[8:0]];

  always @(posedge clk) begin
    if (ram_en) begin
      en_cnt <= en_cnt + 1;
      last_addr <= ram_addr;
      last_mask <= ram_wmask;
      if (ram_wen)
        for (int i = 0; i < 32; i++)
          if (ram_wmask[i]) mem[ram_addr[8:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        flush;
    logic [63:0] exp_rdata;
    int          exp_lat;
    int          exp_ens;
    logic [31:0] exp_wmask;
  } vec_t;
  vec_t vt [11];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [7:0] m);
    @(negedge clk);
    req_valid = 1; req_addr = a; req_wen = w; req_wdata = d; req_wmask = m;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk); resp_ready = 1;
    @(posedge clk); #1; resp_ready = 0;
  endtask

  task automatic txn(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [7:0] m,
                     output logic [63:0] rd, output int lat, output int ens);
    int e0;
    e0 = en_cnt;
    issue(a, w, d, m);
    wait_resp(lat);
    rd = resp_rdata;
    ens = en_cnt - e0;
    handshake();
  endtask

  initial begin
    logic [63:0] rd, held;
    int lat, ens;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[9'h080] = {64'hDEADBEEF_00000001, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h0123_4567_89AB_CDEF};
    mem[9'h081] = {64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555, 64'h4444_0000_8181_0000};
    mem[9'h100] = {64'hCAFEF00D_00000003, 64'hCAFEF00D_00000002, 64'hCAFEF00D_00000001, 64'hCAFEF00D_00000000};
    vt[0]  = '{64'h1018, 0, 64'h0, 8'h00, 0, 64'hDEADBEEF_00000001, 2, 1, 32'h0};
    vt[1]  = '{64'h1000, 0, 64'h0, 8'h00, 0, 64'h0123_4567_89AB_CDEF, 1, 0, 32'h0};
    vt[2]  = '{64'h1008, 1, 64'h1122334455667788, 8'h0F, 0, 64'h0, 2, 1, 32'h0000_0F00};
    vt[3]  = '{64'h1008, 0, 64'h0, 8'h00, 0, 64'h2222_2222_5566_7788, 1, 0, 32'h0};
    vt[4]  = '{64'h2010, 0, 64'h0, 8'h00, 0, 64'hCAFEF00D_00000002, 2, 1, 32'h0};
    vt[5]  = '{64'h1010, 1, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 0, 64'h0, 2, 1, 32'h00FF_0000};
    vt[6]  = '{64'h1010, 0, 64'h0, 8'h00, 0, 64'hAAAA_AAAA_AAAA_AAAA, 2, 1, 32'h0};
    vt[7]  = '{64'h1000, 0, 64'h0, 8'h00, 0, 64'h0123_4567_89AB_CDEF, 1, 0, 32'h0};
    vt[8]  = '{64'h1018, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 64'h0, 2, 1, 32'h0};
    vt[9]  = '{64'h1018, 0, 64'h0, 8'h00, 0, 64'hDEADBEEF_00000001, 1, 0, 32'h0};
    vt[10] = '{64'h1000, 0, 64'h0, 8'h00, 1, 64'h0123_4567_89AB_CDEF, 2, 1, 32'h0};

    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    @(negedge clk); rst_n = 1;

    for (int v = 0; v < 11; v++) begin
      if (vt[v].flush) begin
        @(negedge clk); buf_flush = 1;
        @(negedge clk); buf_flush = 0;
      end
      txn(vt[v].addr, vt[v].wen, vt[v].wdata, vt[v].wmask, rd, lat, ens);
      chk($sformatf("v%0d_rdata", v), rd, vt[v].exp_rdata);
      chk($sformatf("v%0d_latency", v), lat, vt[v].exp_lat);
      chk($sformatf("v%0d_ram_en_count", v), ens, vt[v].exp_ens);
      if (vt[v].exp_ens == 1) begin
        chk($sformatf("v%0d_ram_addr", v), last_addr, vt[v].addr >> 5);
        chk($sformatf("v%0d_ram_wmask", v), last_mask, vt[v].exp_wmask);
      end
    end

    // response stall: outputs hold, no new RAM traffic
    issue(64'h1020, 0, 64'h0, 8'h00);
    wait_resp(lat);
    chk("stall_latency", lat, 2);
    held = resp_rdata;
    chk("stall_rdata", held, 64'h4444_0000_8181_0000);
    ens = en_cnt;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_resp_valid", c), resp_valid, 1);
      chk($sformatf("stall%0d_resp_rdata", c), resp_rdata, held);
      chk($sformatf("stall%0d_req_ready", c), req_ready, 0);
      chk($sformatf("stall%0d_ram_en", c), ram_en, 0);
    end
    chk("stall_ram_en_count", en_cnt - ens, 0);
    handshake();

    // flush in the same cycle as a read fill: the fill must not leave the buffer valid
    issue(64'h2000, 0, 64'h0, 8'h00);
    chk("fill_in_access", ram_en, 1);
    buf_flush = 1;
    @(posedge clk); #1; buf_flush = 0;
    chk("fill_rdata", resp_rdata, 64'hCAFEF00D_00000000);
    handshake();
    txn(64'h2008, 0, 64'h0, 8'h00, rd, lat, ens);
    chk("postflush_latency", lat, 2);
    chk("postflush_ram_en_count", ens, 1);
    chk("postflush_rdata", rd, 64'hCAFEF00D_00000001);

    // reset asserted mid-ACCESS drops the request
    issue(64'h1018, 0, 64'h0, 8'h00);
    chk("rstacc_ram_en_before", ram_en, 1);
    #2 rst_n = 0;
    #1;
    chk("rstacc_ram_en", ram_en, 0);
    chk("rstacc_ram_wen", ram_wen, 0);
    chk("rstacc_resp_valid", resp_valid, 0);
    chk("rstacc_resp_rdata", resp_rdata, 0);
    chk("rstacc_ram_addr", ram_addr, 0);
    @(negedge clk); rst_n = 1;
    ens = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (resp_valid) ens++;
    end
    chk("rstacc_no_resp", ens, 0);
    txn(64'h2010, 0, 64'h0, 8'h00, rd, lat, ens);
    chk("rstacc_miss_latency", lat, 2);
    chk("rstacc_miss_ram_en", ens, 1);
    chk("rstacc_miss_rdata", rd, 64'hCAFEF00D_00000002);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
